// File: rtl/fpu_div_pkg.sv
// Shared definitions for the FPU divide path: significand widths, rounding
// mode encodings and the divider state encoding.
package fpu_div_pkg;

   // Significand width including the hidden bit, and quotient bits produced
   localparam int FPU_MW = 24;
   localparam int FPU_QW = FPU_MW + 2;

   // Rounding mode encodings
   localparam logic [1:0] RM_RNE  = 2'b00;
   localparam logic [1:0] RM_RZ   = 2'b01;
   localparam logic [1:0] RM_PINF = 2'b10;
   localparam logic [1:0] RM_NINF = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_RND  = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_round.sv
// Combinational significand rounder: applies the rounding increment selected
// by the rounding mode to an already-normalised fraction and reports inexact.
// Shared between the divide and multiply rounding paths.
module div_round
   import fpu_div_pkg::*;
#(
   parameter int FW = FPU_MW - 1
)(
   input  logic [FW-1:0] frac,
   input  logic          guard,
   input  logic          sticky,
   input  logic [1:0]    R_mode,
   input  logic          Sz,
   output logic [FW-1:0] Mz,
   output logic          Inexact
);

   function automatic logic round_inc(input logic [1:0] rm, input logic sgn,
                                      input logic g, input logic st, input logic lsb);
      logic r;
      r = 1'b0;
      case (rm)
         RM_RNE:  r = g & (st | lsb);
         RM_RZ:   r = 1'b0;
         RM_PINF: r = ~sgn & (g | st);
         RM_NINF: r = sgn & (g | st);
      endcase
      return r;
   endfunction

   logic inc;

   // Increment and inexact depend only on the discarded bits and the mode
   always_comb begin
      inc     = round_inc(R_mode, Sz, guard, sticky, frac[0]);
      Mz      = frac + FW'(inc);
      Inexact = guard | sticky;
   end

endmodule

// File: rtl/significand_divider.sv
// Iterative restoring significand divider, one quotient bit per clock.
// Produces the normalised, rounded fraction of Mx/My plus SHL, Inexact and
// Div_by_zero flags, with a Start/Done handshake.
// Optional build macro SIGNIFICAND_DIV_EARLY_TERM_EN: stop iterating as soon
// as the partial remainder becomes zero (results unchanged, latency shorter).
module significand_divider
   import fpu_div_pkg::*;
#(
   parameter int MW = FPU_MW,
   parameter int QW = MW + 2
)(
   input  logic          CLK,
   input  logic          RST,
   input  logic          Start,
   input  logic [MW-1:0] Mx,
   input  logic [MW-1:0] My,
   input  logic [1:0]    R_mode,
   input  logic          Sz,
   output logic          Busy,
   output logic          Done,
   output logic [MW-2:0] Mz,
   output logic          SHL,
   output logic          Inexact,
   output logic          Div_by_zero
);

   localparam int CW = $clog2(QW);

   div_state_t    state_q, state_d;
   logic [MW:0]   rem_q, rem_d;
   logic [QW-1:0] q_q, q_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [MW-1:0] my_q, my_d;
   logic [1:0]    rmode_q, rmode_d;
   logic          sz_q, sz_d;
   logic          dbz_q, dbz_d;
   logic          zero_q, zero_d;

   logic [MW:0]   my_ext, rem_step;
   logic          ge;
   logic [QW-1:0] q_step;

   logic [MW-2:0] frac, rnd_mz, mz_d;
   logic          guard, sticky, shl_sel, rnd_inexact;
   logic          done_d, shl_d, inx_d, dz_out_d;

   assign Busy = (state_q != ST_IDLE);

   // One restoring step: compare, conditionally subtract, shift remainder
   always_comb begin
      my_ext   = {1'b0, my_q};
      ge       = (rem_q >= my_ext);
      rem_step = ge ? ((rem_q - my_ext) << 1) : (rem_q << 1);
      q_step   = {q_q[QW-2:0], ge};
   end

   // Normalisation: pick fraction, guard and sticky by the quotient MSB
   always_comb begin
      frac    = q_q[QW-2:2];
      guard   = q_q[1];
      sticky  = q_q[0] | (rem_q != '0);
      shl_sel = 1'b0;
      if (!q_q[QW-1]) begin
         frac    = q_q[QW-3:1];
         guard   = q_q[0];
         sticky  = (rem_q != '0);
         shl_sel = 1'b1;
      end
   end

   div_round #(.FW(MW-1)) u_round (
      .frac    (frac),
      .guard   (guard),
      .sticky  (sticky),
      .R_mode  (rmode_q),
      .Sz      (sz_q),
      .Mz      (rnd_mz),
      .Inexact (rnd_inexact)
   );

   // Next-state, datapath update and result capture
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      q_d      = q_q;
      cnt_d    = cnt_q;
      my_d     = my_q;
      rmode_d  = rmode_q;
      sz_d     = sz_q;
      dbz_d    = dbz_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      mz_d     = Mz;
      shl_d    = SHL;
      inx_d    = Inexact;
      dz_out_d = Div_by_zero;
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               my_d    = My;
               rmode_d = R_mode;
               sz_d    = Sz;
               rem_d   = {1'b0, Mx};
               q_d     = '0;
               cnt_d   = CW'(QW - 1);
               dbz_d   = ~My[MW-1];
               zero_d  = ~Mx[MW-1];
               state_d = (~My[MW-1] | ~Mx[MW-1]) ? ST_RND : ST_DIV;
            end
         end
         ST_DIV: begin
            rem_d = rem_step;
            q_d   = q_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = ST_RND;
            end
`ifdef SIGNIFICAND_DIV_EARLY_TERM_EN
            else if (rem_step == '0) begin
               // Remaining quotient bits are all zero: align and finish now
               q_d     = q_step << cnt_q;
               cnt_d   = '0;
               state_d = ST_RND;
            end
`endif
         end
         ST_RND: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
            if (dbz_q | zero_q) begin
               mz_d     = '0;
               shl_d    = 1'b0;
               inx_d    = 1'b0;
               dz_out_d = dbz_q;
            end else begin
               mz_d     = rnd_mz;
               shl_d    = shl_sel;
               inx_d    = rnd_inexact;
               dz_out_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state and visible results, cleared by reset
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= ST_IDLE;
         Done        <= 1'b0;
         Mz          <= '0;
         SHL         <= 1'b0;
         Inexact     <= 1'b0;
         Div_by_zero <= 1'b0;
      end else begin
         state_q     <= state_d;
         Done        <= done_d;
         Mz          <= mz_d;
         SHL         <= shl_d;
         Inexact     <= inx_d;
         Div_by_zero <= dz_out_d;
      end
   end

   // Working registers; always loaded on Start before being consumed
   always_ff @(posedge CLK) begin
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      my_q    <= my_d;
      rmode_q <= rmode_d;
      sz_q    <= sz_d;
      dbz_q   <= dbz_d;
      zero_q  <= zero_d;
   end

endmodule

// File: tb/tb_significand_divider.sv
// Scoreboard testbench for significand_divider: directed test-plan cases
// followed by randomized operations, checked against an arithmetic model.
module tb_significand_divider;

   localparam int MW = 24;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          Start = 1'b0;
   logic [MW-1:0] Mx = '0;
   logic [MW-1:0] My = '0;
   logic [1:0]    R_mode = 2'b00;
   logic          Sz = 1'b0;
   logic          Busy, Done, SHL, Inexact, Div_by_zero;
   logic [MW-2:0] Mz;

   typedef struct {
      logic [MW-2:0] mz;
      logic          shl;
      logic          inx;
      logic          dbz;
      int            lat;
      int            due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   significand_divider dut (
      .CLK         (CLK),
      .RST         (RST),
      .Start       (Start),
      .Mx          (Mx),
      .My          (My),
      .R_mode      (R_mode),
      .Sz          (Sz),
      .Busy        (Busy),
      .Done        (Done),
      .Mz          (Mz),
      .SHL         (SHL),
      .Inexact     (Inexact),
      .Div_by_zero (Div_by_zero)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: exact quotient by integer division, then normalise and round
   function automatic exp_t model(input logic [MW-1:0] mx, input logic [MW-1:0] my,
                                  input logic [1:0] rm, input logic sz);
      exp_t e;
      longint unsigned mxl, myl, num, q, r, frac;
      logic g, s, inc;
      e.mz = '0; e.shl = 1'b0; e.inx = 1'b0; e.dbz = 1'b0; e.lat = 1; e.due = 0;
      if (!my[MW-1]) begin
         e.dbz = 1'b1;
         return e;
      end
      if (!mx[MW-1]) return e;
      mxl = 64'(mx);
      myl = 64'(my);
      num = mxl << 25;
      q   = num / myl;
      r   = num % myl;
      if (q >= (64'd1 << 25)) begin
         frac = q >> 2; g = q[1]; s = q[0] | (r != 0); e.shl = 1'b0;
      end else begin
         frac = q >> 1; g = q[0]; s = (r != 0); e.shl = 1'b1;
      end
      case (rm)
         2'b00:   inc = g & (s | frac[0]);
         2'b01:   inc = 1'b0;
         2'b10:   inc = ~sz & (g | s);
         default: inc = sz & (g | s);
      endcase
      e.mz  = 23'((frac + 64'(inc)) & 64'h7F_FFFF);
      e.inx = g | s;
      e.lat = 27;
`ifdef SIGNIFICAND_DIV_EARLY_TERM_EN
      for (int i = 1; i <= 25; i++) begin
         if (((mxl << (i - 1)) % myl) == 0) begin
            e.lat = i + 1;
            break;
         end
      end
`endif
      return e;
   endfunction

   // Issue one operation from a negedge; returns at the negedge Done is seen
   task automatic run_op(input logic [MW-1:0] mx, input logic [MW-1:0] my,
                         input logic [1:0] rm, input logic sz,
                         input int glitch_at, input int rst_at);
      exp_t e;
      int   busy_n;
      bit   seen;
      e     = model(mx, my, rm, sz);
      e.due = cyc + 1 + e.lat;
      Mx = mx; My = my; R_mode = rm; Sz = sz; Start = 1'b1;
      sb.push_back(e);
      @(negedge CLK);
      Start = 1'b0;
      Mx = MW'($urandom); My = MW'($urandom); R_mode = 2'($urandom); Sz = 1'($urandom);
      busy_n = 0;
      seen   = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if (n == rst_at) begin
            RST = 1'b0;
            #1;
            chk("rst_busy", Busy, 0);
            chk("rst_done", Done, 0);
            chk("rst_mz", Mz, 0);
            chk("rst_shl", SHL, 0);
            chk("rst_inexact", Inexact, 0);
            chk("rst_dbz", Div_by_zero, 0);
            sb.delete(sb.size() - 1);
            repeat (3) @(negedge CLK);
            RST = 1'b1;
            return;
         end
         if (n == glitch_at) begin
            Start = 1'b1; Mx = 24'hFFFFFF; My = 24'h800000; R_mode = 2'b10; Sz = 1'b0;
         end else if (glitch_at >= 0 && n == glitch_at + 1) begin
            Start = 1'b0;
         end
         if (Busy) busy_n++;
         if (Done) begin
            seen = 1'b1;
            break;
         end
         @(negedge CLK);
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no Done within 60 cycles, expected latency %0d", e.lat);
      end else begin
         chk("busy_cycles", busy_n, e.lat);
      end
   endtask

   // Monitor: every Done must match the oldest outstanding expectation
   always @(negedge CLK) begin
      exp_t e;
      if (Done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: Done with no outstanding operation at cycle %0d", cyc);
         end else begin
            e = sb.pop_front();
            chk("mz", Mz, e.mz);
            chk("shl", SHL, e.shl);
            chk("inexact", Inexact, e.inx);
            chk("div_by_zero", Div_by_zero, e.dbz);
            chk("done_cycle", cyc, e.due);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [MW-1:0] a, b;
      int            kind;
      repeat (2) @(negedge CLK);
      chk("reset_busy", Busy, 0);
      chk("reset_done", Done, 0);
      chk("reset_mz", Mz, 0);
      chk("reset_shl", SHL, 0);
      chk("reset_inexact", Inexact, 0);
      chk("reset_dbz", Div_by_zero, 0);
      RST = 1'b1;
      @(negedge CLK);

      // Test-plan directed cases
      run_op(24'hC00000, 24'h800000, 2'b00, 1'b0, -1, -1);
      run_op(24'h800000, 24'hC00000, 2'b00, 1'b0, -1, -1);
      run_op(24'h800000, 24'hC00000, 2'b01, 1'b0, -1, -1);
      run_op(24'h800000, 24'hC00000, 2'b11, 1'b0, -1, -1);
      run_op(24'h800000, 24'hC00000, 2'b10, 1'b0, -1, -1);
      run_op(24'h800000, 24'hC00000, 2'b10, 1'b1, -1, -1);
      run_op(24'h800000, 24'hC00000, 2'b11, 1'b1, -1, -1);
      run_op(24'h900000, 24'h000000, 2'b00, 1'b0, -1, -1);
      run_op(24'h000000, 24'h800000, 2'b00, 1'b0, -1, -1);
      run_op(24'hA00000, 24'hE00000, 2'b00, 1'b0, 5, -1);
      run_op(24'h800000, 24'h800000, 2'b00, 1'b0, -1, -1);
      run_op(24'hFFFFFF, 24'h800001, 2'b10, 1'b0, -1, -1);
      run_op(24'hD12345, 24'h9ABCDE, 2'b00, 1'b1, -1, 10);
      run_op(24'hD12345, 24'h9ABCDE, 2'b00, 1'b1, -1, -1);

      // Randomized operations, mostly back-to-back, some with idle gaps
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge CLK);
         kind = int'($urandom_range(0, 9));
         a = 24'h800000 | MW'($urandom);
         b = 24'h800000 | MW'($urandom);
         if (kind == 0) b = MW'($urandom_range(0, 24'h7FFFFF));
         else if (kind == 1) a = MW'($urandom_range(0, 24'h7FFFFF));
         else if (kind == 2) b = a;
         else if (kind == 3) b = 24'h800000;
         run_op(a, b, 2'($urandom), 1'($urandom), -1, -1);
      end

      repeat (3) @(negedge CLK);
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
